// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardware clear sequencer and dropped-write reporting.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_rd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] q,
  input  logic              busy,
  input  logic              fwd,
  input  logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] data
);
  logic zero_hit;
  assign zero_hit = (ZERO_REG != 0) && (addr == '0);
  assign data     = (busy || zero_hit) ? '0 : (fwd ? fwd_data : q);
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     wr_drop
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]                      state;
  logic [ADDR_W-1:0]               clr_ptr;
  logic [DEPTH-1:0][DATA_W-1:0]    mem;
  logic [NUM_RD-1:0][ADDR_W-1:0]   ra;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd;
  logic [NUM_RD-1:0]               fwd;
  logic                            wr_ok;

  assign busy    = (state == CLEAR);
  assign wr_ok   = wr_en && !busy && !((ZERO_REG != 0) && (wr_addr == '0));
  assign ra      = rd_addr;
  assign rd_data = rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && busy;
      if (state == CLEAR) begin
        // a restart request wins over finishing the sweep
        if (clr_req) begin
          clr_ptr <= '0;
        end else begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == {ADDR_W{1'b1}}) state <= READY;
        end
      end else if (clr_req) begin
        state   <= CLEAR;
        clr_ptr <= '0;
      end
    end
  end

  // array has no reset; the sweep is what zeroes it
  always_ff @(posedge clk) begin
    if (busy)       mem[clr_ptr] <= '0;
    else if (wr_ok) mem[wr_addr] <= wr_data;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
    assign fwd[k] = wr_ok && (wr_addr == ra[k]);
`else
    assign fwd[k] = 1'b0;
`endif
    regfile_mp_rd #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .addr     (ra[k]),
      .q        (mem[ra[k]]),
      .busy     (busy),
      .fwd      (fwd[k]),
      .fwd_data (wr_data),
      .data     (rd[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32 two-port build plus an 8x16 four-port build.
module tb_regfile_mp;
  logic        clk;
  logic        rst_n, clr_req, wr_en, busy, wr_drop;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic        rst8_n, clr8, wen8, busy8, drop8;
  logic [11:0] ra8;
  logic [63:0] rd8;
  logic [2:0]  wa8;
  logic [15:0] wd8;

  int n_chk, n_fail, cnt;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .wr_drop(wr_drop)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1)) dut8 (
    .clk(clk), .rst_n(rst8_n), .clr_req(clr8), .rd_addr(ra8), .rd_data(rd8),
    .wr_en(wen8), .wr_addr(wa8), .wr_data(wd8), .busy(busy8), .wr_drop(drop8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; clr_req = 1'b0; wr_en = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    rst8_n = 1'b0; clr8 = 1'b0; wen8 = 1'b0; ra8 = '0; wa8 = '0; wd8 = '0;
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_drop", 32'(wr_drop), 32'd0);

    // reset release with an immediate write to r5
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
      if (cnt == 1) begin
        check("drop_after_rst_wr", 32'(wr_drop), 32'd1);
        wr_en = 1'b0;
      end else if (cnt == 2) begin
        check("drop_one_cycle", 32'(wr_drop), 32'd0);
      end
    end
    check("rst_busy_len", 32'(cnt), 32'd32);
    rd_addr = {5'd0, 5'd5};
    #1 check("r5_after_clear", rd_data[31:0], 32'd0);

    // basic write/read on both ports
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr = {5'd7, 5'd7};
    tick();
    wr_en = 1'b0;
    #1;
    check("r7_port0", rd_data[31:0],  32'h12345678);
    check("r7_port1", rd_data[63:32], 32'h12345678);

    // hardwired zero register
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd7, 5'd0};
    #1 check("r0_same_cycle", rd_data[31:0], 32'd0);
    tick();
    wr_en = 1'b0;
    #1;
    check("r0_reads_zero", rd_data[31:0], 32'd0);
    check("r0_no_drop", 32'(wr_drop), 32'd0);

    // forwarding behaviour
    rd_addr = {5'd7, 5'd3};
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r3_bypass", rd_data[31:0], 32'hA5A5A5A5);
`else
    check("r3_no_bypass", rd_data[31:0], 32'd0);
`endif
    check("r7_unaffected", rd_data[63:32], 32'h12345678);
    tick();
    wr_en = 1'b0;
    #1 check("r3_next_cycle", rd_data[31:0], 32'hA5A5A5A5);

    // fill r1..r31 with their index
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0;
    rd_addr = {5'd1, 5'd31};
    #1;
    check("fill_r31", rd_data[31:0],  32'd31);
    check("fill_r1",  rd_data[63:32], 32'd1);

    // single clr_req pulse
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #1 check("rd_zero_while_busy", rd_data[31:0], 32'd0);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
    check("clr_busy_len", 32'(cnt), 32'd32);
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      check("clr_zero_p0", rd_data[31:0],  32'd0);
      check("clr_zero_p1", rd_data[63:32], 32'd0);
    end

    // restart the sweep at its 10th edge
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd4;
    tick();
    wr_en = 1'b0;
    rd_addr = {5'd0, 5'd4};
    #1 check("r4_written", rd_data[31:0], 32'd4);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (cnt == 10) clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
    end
    check("restart_busy_len", 32'(cnt), 32'd42);
    #1 check("r4_after_restart", rd_data[31:0], 32'd0);

    // 8-entry, 16-bit, 4-port build
    rst8_n = 1'b1;
    cnt = 0;
    while (busy8 && cnt < 200) begin
      cnt++;
      tick();
    end
    check("p8_busy_len", 32'(cnt), 32'd8);
    wen8 = 1'b1; wa8 = 3'd6; wd8 = 16'hBEEF; ra8 = {4{3'd6}};
    tick();
    wen8 = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) check("p8_port_beef", 32'(rd8[k*16 +: 16]), 32'h0000BEEF);

    // asynchronous reset in the middle of a write
    wen8 = 1'b1; wa8 = 3'd2; wd8 = 16'h1234;
    #1 rst8_n = 1'b0;
    #1;
    check("p8_async_rst_busy", 32'(busy8), 32'd1);
    check("p8_async_rst_rd", 32'(rd8[15:0]), 32'd0);
    wen8 = 1'b0;
    tick();
    rst8_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
